// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the IF/ID/EX/MEM pipeline.
// Hazard outputs are combinational. The multi-cycle sequencer and the perf counters are registered.
module pipeline_hazard_ctrl #(
   parameter int RA_W    = 5,
   parameter int MUL_LAT = 4,
   parameter int FWD_EN  = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RA_W-1:0]   d_rs,
   input  logic [RA_W-1:0]   d_rt,
   input  logic              d_use_rs,
   input  logic              d_use_rt,
   input  logic [RA_W-1:0]   x_rd,
   input  logic              x_wen,
   input  logic              x_lw,
   input  logic              x_mul_start,
   input  logic              x_branch_taken,
   input  logic [RA_W-1:0]   m_rd,
   input  logic              m_wen,
   input  logic [RA_W-1:0]   w_rd,
   input  logic              w_wen,
   output logic              pc_stall,
   output logic              fd_stall,
   output logic              dx_bubble,
   output logic              dx_hold,
   output logic              xm_bubble,
   output logic              fd_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              ex_busy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int               MC_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
   localparam logic [MC_W-1:0]  MC_INIT = MC_W'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [MC_W-1:0]   cnt_r;
   logic [MC_W-1:0]   cnt_s;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic [CNT_W-1:0]  flush_cnt_r;
   logic              x_hit_s;
   logic              m_hit_s;
   logic              stall_req_s;
   logic [1:0]        fwd_a_s;
   logic [1:0]        fwd_b_s;

   // A source depends on a producer only if it is read, written, and not register 0.
   function automatic logic reg_hit(input logic [RA_W-1:0] src, input logic use_src,
                                    input logic [RA_W-1:0] dst, input logic wen);
      reg_hit = use_src && wen && (src != {RA_W{1'b0}}) && (src == dst);
   endfunction

   // MEM result is younger than WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src, input logic use_src);
      if (reg_hit(src, use_src, m_rd, m_wen)) begin
         fwd_sel = 2'b01;
      end else if (reg_hit(src, use_src, w_rd, w_wen)) begin
         fwd_sel = 2'b10;
      end else begin
         fwd_sel = 2'b00;
      end
   endfunction

   // Dependence detection against EX and MEM producers, and operand forwarding selects.
   always_comb begin
      x_hit_s = reg_hit(d_rs, d_use_rs, x_rd, x_wen) || reg_hit(d_rt, d_use_rt, x_rd, x_wen);
      m_hit_s = reg_hit(d_rs, d_use_rs, m_rd, m_wen) || reg_hit(d_rt, d_use_rt, m_rd, m_wen);
      if (FWD_EN != 0) begin
         stall_req_s = x_lw && x_hit_s;
         fwd_a_s     = fwd_sel(d_rs, d_use_rs);
         fwd_b_s     = fwd_sel(d_rt, d_use_rt);
      end else begin
         stall_req_s = x_hit_s || m_hit_s;
         fwd_a_s     = 2'b00;
         fwd_b_s     = 2'b00;
      end
   end

   // Multi-cycle sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {MC_W{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Sequencer next state; a taken branch in the start cycle cancels the multiply.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (x_mul_start && !x_branch_taken) begin
               state_s = ST_BUSY;
               cnt_s   = MC_INIT;
            end else begin
               state_s = ST_IDLE;
               cnt_s   = {MC_W{1'b0}};
            end
         end
         ST_BUSY: begin
            if (cnt_r == {MC_W{1'b0}}) begin
               state_s = ST_IDLE;
               cnt_s   = {MC_W{1'b0}};
            end else begin
               state_s = ST_BUSY;
               cnt_s   = cnt_r - MC_W'(1'b1);
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = {MC_W{1'b0}};
         end
      endcase
   end

   // Pipeline control outputs: reset, then busy EX, then flush, then dependence stall.
   always_comb begin
      pc_stall  = 1'b0;
      fd_stall  = 1'b0;
      dx_bubble = 1'b0;
      dx_hold   = 1'b0;
      xm_bubble = 1'b0;
      fd_flush  = 1'b0;
      ex_busy   = 1'b0;
      fwd_a     = fwd_a_s;
      fwd_b     = fwd_b_s;
      if (rst) begin
         dx_bubble = 1'b1;
         fd_flush  = 1'b1;
         fwd_a     = 2'b00;
         fwd_b     = 2'b00;
      end else if (state_r == ST_BUSY) begin
         ex_busy   = 1'b1;
         pc_stall  = 1'b1;
         fd_stall  = 1'b1;
         dx_hold   = 1'b1;
         xm_bubble = 1'b1;
      end else if (x_branch_taken) begin
         fd_flush  = 1'b1;
         dx_bubble = 1'b1;
      end else if (stall_req_s) begin
         pc_stall  = 1'b1;
         fd_stall  = 1'b1;
         dx_bubble = 1'b1;
      end else begin
         pc_stall  = 1'b0;
      end
   end

   // Saturating stall and flush performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (pc_stall && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (fd_flush && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1'b1);
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances share stimulus (default, no-forwarding, 4-bit counters).
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
   localparam int RA_W = 5;
   localparam int MUL_LAT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic [RA_W-1:0] d_rs, d_rt, x_rd, m_rd, w_rd;
   logic d_use_rs, d_use_rt, x_wen, x_lw, x_mul_start, x_branch_taken, m_wen, w_wen;

   logic a_pc_stall, a_fd_stall, a_dx_bubble, a_dx_hold, a_xm_bubble, a_fd_flush, a_ex_busy;
   logic n_pc_stall, n_fd_stall, n_dx_bubble, n_dx_hold, n_xm_bubble, n_fd_flush, n_ex_busy;
   logic s_pc_stall, s_fd_stall, s_dx_bubble, s_dx_hold, s_xm_bubble, s_fd_flush, s_ex_busy;
   logic [1:0] a_fwd_a, a_fwd_b, n_fwd_a, n_fwd_b, s_fwd_a, s_fwd_b;
   logic [15:0] a_stall_cnt, a_flush_cnt, n_stall_cnt, n_flush_cnt;
   logic [3:0] s_stall_cnt, s_flush_cnt;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl #(.RA_W(RA_W), .MUL_LAT(MUL_LAT), .FWD_EN(1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
      .x_rd(x_rd), .x_wen(x_wen), .x_lw(x_lw), .x_mul_start(x_mul_start),
      .x_branch_taken(x_branch_taken), .m_rd(m_rd), .m_wen(m_wen), .w_rd(w_rd), .w_wen(w_wen),
      .pc_stall(a_pc_stall), .fd_stall(a_fd_stall), .dx_bubble(a_dx_bubble), .dx_hold(a_dx_hold),
      .xm_bubble(a_xm_bubble), .fd_flush(a_fd_flush), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
      .ex_busy(a_ex_busy), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

   pipeline_hazard_ctrl #(.RA_W(RA_W), .MUL_LAT(MUL_LAT), .FWD_EN(0), .CNT_W(16)) dut_nf (
      .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
      .x_rd(x_rd), .x_wen(x_wen), .x_lw(x_lw), .x_mul_start(x_mul_start),
      .x_branch_taken(x_branch_taken), .m_rd(m_rd), .m_wen(m_wen), .w_rd(w_rd), .w_wen(w_wen),
      .pc_stall(n_pc_stall), .fd_stall(n_fd_stall), .dx_bubble(n_dx_bubble), .dx_hold(n_dx_hold),
      .xm_bubble(n_xm_bubble), .fd_flush(n_fd_flush), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
      .ex_busy(n_ex_busy), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt));

   pipeline_hazard_ctrl #(.RA_W(RA_W), .MUL_LAT(MUL_LAT), .FWD_EN(1), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
      .x_rd(x_rd), .x_wen(x_wen), .x_lw(x_lw), .x_mul_start(x_mul_start),
      .x_branch_taken(x_branch_taken), .m_rd(m_rd), .m_wen(m_wen), .w_rd(w_rd), .w_wen(w_wen),
      .pc_stall(s_pc_stall), .fd_stall(s_fd_stall), .dx_bubble(s_dx_bubble), .dx_hold(s_dx_hold),
      .xm_bubble(s_xm_bubble), .fd_flush(s_fd_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
      .ex_busy(s_ex_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

   task automatic set_idle();
      d_rs = '0; d_rt = '0; d_use_rs = 1'b0; d_use_rt = 1'b0;
      x_rd = '0; x_wen = 1'b0; x_lw = 1'b0; x_mul_start = 1'b0; x_branch_taken = 1'b0;
      m_rd = '0; m_wen = 1'b0; w_rd = '0; w_wen = 1'b0;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle();
      advance();
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      d_rs = 5'd3; d_use_rs = 1'b1; m_rd = 5'd3; m_wen = 1'b1; x_mul_start = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_pc_stall, a_fd_stall, a_dx_bubble, a_dx_hold, a_xm_bubble, a_fd_flush, a_ex_busy} !== 7'b0010010) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 0010010",
                  {a_pc_stall, a_fd_stall, a_dx_bubble, a_dx_hold, a_xm_bubble, a_fd_flush, a_ex_busy});
      end
      checks++;
      if (a_fwd_a !== 2'b00) begin
         errors++; $display("FAIL reset_fwd: got %b want 00", a_fwd_a);
      end
      advance();
      advance();
      rst = 1'b0;
      set_idle();
      @(negedge clk);
      checks++;
      if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0 || a_ex_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt: got stall=%0d flush=%0d busy=%b want 0 0 0", a_stall_cnt, a_flush_cnt, a_ex_busy);
      end
      checks++;
      if (a_fd_flush !== 1'b0 || a_dx_bubble !== 1'b0) begin
         errors++; $display("FAIL reset_release: got flush=%b bubble=%b want 0 0", a_fd_flush, a_dx_bubble);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      x_lw = 1'b1; x_wen = 1'b1; x_rd = 5'd8; d_rs = 5'd8; d_use_rs = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_pc_stall, a_fd_stall, a_dx_bubble, a_dx_hold, a_fd_flush} !== 5'b11100) begin
         errors++; $display("FAIL load_use: got %b want 11100", {a_pc_stall, a_fd_stall, a_dx_bubble, a_dx_hold, a_fd_flush});
      end
      advance();
      set_idle();
      @(negedge clk);
      checks++;
      if (a_pc_stall !== 1'b0 || a_stall_cnt !== 16'd1) begin
         errors++; $display("FAIL load_use_cnt: got stall=%b cnt=%0d want 0 1", a_pc_stall, a_stall_cnt);
      end
      advance();
      x_lw = 1'b1; x_wen = 1'b1; x_rd = 5'd0; d_rs = 5'd0; d_use_rs = 1'b1;
      @(negedge clk);
      checks++;
      if (a_pc_stall !== 1'b0 || n_pc_stall !== 1'b0) begin
         errors++; $display("FAIL load_use_r0: got %b %b want 0 0", a_pc_stall, n_pc_stall);
      end
      advance();
      set_idle();
   endtask

   task automatic test_forward();
      do_reset();
      m_rd = 5'd9; w_rd = 5'd9; m_wen = 1'b1; w_wen = 1'b1; d_rt = 5'd9; d_use_rt = 1'b1;
      @(negedge clk);
      checks++;
      if (a_fwd_b !== 2'b01 || a_pc_stall !== 1'b0) begin
         errors++; $display("FAIL fwd_mem: got fwd_b=%b stall=%b want 01 0", a_fwd_b, a_pc_stall);
      end
      checks++;
      if (n_fwd_b !== 2'b00 || n_pc_stall !== 1'b1 || n_dx_bubble !== 1'b1) begin
         errors++; $display("FAIL nofwd_stall: got fwd_b=%b stall=%b bubble=%b want 00 1 1", n_fwd_b, n_pc_stall, n_dx_bubble);
      end
      m_wen = 1'b0;
      #1;
      checks++;
      if (a_fwd_b !== 2'b10 || n_pc_stall !== 1'b0) begin
         errors++; $display("FAIL fwd_wb: got fwd_b=%b nf_stall=%b want 10 0", a_fwd_b, n_pc_stall);
      end
      d_use_rt = 1'b0;
      #1;
      checks++;
      if (a_fwd_b !== 2'b00) begin
         errors++; $display("FAIL fwd_unused: got %b want 00", a_fwd_b);
      end
      m_rd = 5'd0; m_wen = 1'b1; d_rs = 5'd0; d_use_rs = 1'b1;
      #1;
      checks++;
      if (a_fwd_a !== 2'b00) begin
         errors++; $display("FAIL fwd_r0: got %b want 00", a_fwd_a);
      end
      advance();
      set_idle();
   endtask

   task automatic test_mul();
      do_reset();
      x_mul_start = 1'b1;
      @(negedge clk);
      checks++;
      if (a_ex_busy !== 1'b0 || a_pc_stall !== 1'b0) begin
         errors++; $display("FAIL mul_start: got busy=%b stall=%b want 0 0", a_ex_busy, a_pc_stall);
      end
      advance();
      set_idle();
      for (int i = 0; i < 3; i++) begin
         x_mul_start = (i == 1) ? 1'b1 : 1'b0;
         @(negedge clk);
         checks++;
         if ({a_ex_busy, a_pc_stall, a_fd_stall, a_dx_hold, a_xm_bubble, a_dx_bubble} !== 6'b111110) begin
            errors++;
            $display("FAIL mul_busy%0d: got %b want 111110", i,
                     {a_ex_busy, a_pc_stall, a_fd_stall, a_dx_hold, a_xm_bubble, a_dx_bubble});
         end
         advance();
      end
      set_idle();
      @(negedge clk);
      checks++;
      if (a_ex_busy !== 1'b0 || a_stall_cnt !== 16'd3) begin
         errors++; $display("FAIL mul_end: got busy=%b cnt=%0d want 0 3", a_ex_busy, a_stall_cnt);
      end
      advance();
   endtask

   task automatic test_branch();
      do_reset();
      x_branch_taken = 1'b1; x_lw = 1'b1; x_wen = 1'b1; x_rd = 5'd4; d_rs = 5'd4; d_use_rs = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_fd_flush, a_dx_bubble, a_pc_stall, a_fd_stall} !== 4'b1100) begin
         errors++; $display("FAIL branch_ctl: got %b want 1100", {a_fd_flush, a_dx_bubble, a_pc_stall, a_fd_stall});
      end
      advance();
      set_idle();
      x_branch_taken = 1'b1; x_mul_start = 1'b1;
      @(negedge clk);
      checks++;
      if (a_flush_cnt !== 16'd1 || a_stall_cnt !== 16'd0) begin
         errors++; $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1 0", a_flush_cnt, a_stall_cnt);
      end
      advance();
      set_idle();
      @(negedge clk);
      checks++;
      if (a_ex_busy !== 1'b0 || a_flush_cnt !== 16'd2) begin
         errors++; $display("FAIL branch_mul: got busy=%b flush=%0d want 0 2", a_ex_busy, a_flush_cnt);
      end
      advance();
   endtask

   task automatic test_reset_busy();
      int busy_cycles;
      do_reset();
      x_mul_start = 1'b1;
      advance();
      set_idle();
      advance();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_ex_busy, a_pc_stall, a_xm_bubble, a_dx_hold, a_dx_bubble, a_fd_flush} !== 6'b000011) begin
         errors++;
         $display("FAIL rst_busy: got %b want 000011", {a_ex_busy, a_pc_stall, a_xm_bubble, a_dx_hold, a_dx_bubble, a_fd_flush});
      end
      advance();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a_ex_busy !== 1'b0) begin
         errors++; $display("FAIL rst_abort: got busy=%b want 0", a_ex_busy);
      end
      advance();
      x_mul_start = 1'b1;
      advance();
      set_idle();
      busy_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (a_ex_busy === 1'b1) busy_cycles++;
         advance();
      end
      checks++;
      if (busy_cycles !== 3) begin
         errors++; $display("FAIL rst_restart: got %0d busy cycles want 3", busy_cycles);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      x_lw = 1'b1; x_wen = 1'b1; x_rd = 5'd12; d_rt = 5'd12; d_use_rt = 1'b1;
      repeat (20) advance();
      set_idle();
      @(negedge clk);
      checks++;
      if (s_stall_cnt !== 4'd15 || a_stall_cnt !== 16'd20) begin
         errors++; $display("FAIL saturate: got sat=%0d wide=%0d want 15 20", s_stall_cnt, a_stall_cnt);
      end
      advance();
   endtask

   task automatic test_random();
      int busy_left;
      int sc_a, fc_a, sc_n, fc_n, sc_s, fc_s;
      logic [6:0] e_ctl_a, e_ctl_n;
      logic [1:0] e_fa, e_fb;
      logic dep_x, dep_m, lu;
      logic [RA_W-1:0] srcs [2];
      logic uses [2];
      logic [1:0] sel [2];
      do_reset();
      busy_left = 0;
      sc_a = 0; fc_a = 0; sc_n = 0; fc_n = 0; sc_s = 0; fc_s = 0;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(39, 0) == 0);
         d_rs = RA_W'($urandom_range(3, 0)); d_rt = RA_W'($urandom_range(3, 0));
         d_use_rs = 1'($urandom_range(1, 0)); d_use_rt = 1'($urandom_range(1, 0));
         x_rd = RA_W'($urandom_range(3, 0)); x_wen = 1'($urandom_range(1, 0));
         x_lw = ($urandom_range(2, 0) == 0);
         x_mul_start = ($urandom_range(9, 0) == 0);
         x_branch_taken = ($urandom_range(7, 0) == 0);
         m_rd = RA_W'($urandom_range(3, 0)); m_wen = 1'($urandom_range(1, 0));
         w_rd = RA_W'($urandom_range(3, 0)); w_wen = 1'($urandom_range(1, 0));
         // Reference: which producers each used nonzero source depends on.
         srcs[0] = d_rs; srcs[1] = d_rt; uses[0] = d_use_rs; uses[1] = d_use_rt;
         dep_x = 1'b0; dep_m = 1'b0;
         for (int k = 0; k < 2; k++) begin
            sel[k] = 2'b00;
            if (uses[k] && srcs[k] != 0) begin
               if (x_wen && x_rd == srcs[k]) dep_x = 1'b1;
               if (m_wen && m_rd == srcs[k]) dep_m = 1'b1;
               if (m_wen && m_rd == srcs[k]) sel[k] = 2'b01;
               else if (w_wen && w_rd == srcs[k]) sel[k] = 2'b10;
            end
         end
         lu = x_lw && dep_x;
         // ctl order: pc_stall fd_stall dx_bubble dx_hold xm_bubble fd_flush ex_busy
         if (rst) begin
            e_ctl_a = 7'b0010010; e_ctl_n = 7'b0010010; e_fa = 2'b00; e_fb = 2'b00;
         end else begin
            e_fa = sel[0]; e_fb = sel[1];
            if (busy_left > 0) begin
               e_ctl_a = 7'b1101101; e_ctl_n = 7'b1101101;
            end else if (x_branch_taken) begin
               e_ctl_a = 7'b0010010; e_ctl_n = 7'b0010010;
            end else begin
               e_ctl_a = lu ? 7'b1110000 : 7'b0000000;
               e_ctl_n = (dep_x || dep_m) ? 7'b1110000 : 7'b0000000;
            end
         end
         @(negedge clk);
         checks++;
         if ({a_pc_stall, a_fd_stall, a_dx_bubble, a_dx_hold, a_xm_bubble, a_fd_flush, a_ex_busy, a_fwd_a, a_fwd_b}
             !== {e_ctl_a, e_fa, e_fb}) begin
            errors++;
            $display("FAIL rand_fwd_out c=%0d: got %b want %b", c,
                     {a_pc_stall, a_fd_stall, a_dx_bubble, a_dx_hold, a_xm_bubble, a_fd_flush, a_ex_busy, a_fwd_a, a_fwd_b},
                     {e_ctl_a, e_fa, e_fb});
         end
         checks++;
         if ({n_pc_stall, n_fd_stall, n_dx_bubble, n_dx_hold, n_xm_bubble, n_fd_flush, n_ex_busy, n_fwd_a, n_fwd_b}
             !== {e_ctl_n, 4'b0000}) begin
            errors++;
            $display("FAIL rand_nofwd_out c=%0d: got %b want %b", c,
                     {n_pc_stall, n_fd_stall, n_dx_bubble, n_dx_hold, n_xm_bubble, n_fd_flush, n_ex_busy, n_fwd_a, n_fwd_b},
                     {e_ctl_n, 4'b0000});
         end
         checks++;
         if (a_stall_cnt !== 16'(sc_a) || a_flush_cnt !== 16'(fc_a) || n_stall_cnt !== 16'(sc_n) ||
             n_flush_cnt !== 16'(fc_n) || s_stall_cnt !== 4'(sc_s) || s_flush_cnt !== 4'(fc_s)) begin
            errors++;
            $display("FAIL rand_cnt c=%0d: got %0d/%0d %0d/%0d %0d/%0d want %0d/%0d %0d/%0d %0d/%0d", c,
                     a_stall_cnt, a_flush_cnt, n_stall_cnt, n_flush_cnt, s_stall_cnt, s_flush_cnt,
                     sc_a, fc_a, sc_n, fc_n, sc_s, fc_s);
         end
         if (rst) begin
            busy_left = 0;
            sc_a = 0; fc_a = 0; sc_n = 0; fc_n = 0; sc_s = 0; fc_s = 0;
         end else begin
            sc_a += e_ctl_a[6]; fc_a += e_ctl_a[1];
            sc_n += e_ctl_n[6]; fc_n += e_ctl_n[1];
            sc_s = (sc_s + e_ctl_a[6] > 15) ? 15 : sc_s + e_ctl_a[6];
            fc_s = (fc_s + e_ctl_a[1] > 15) ? 15 : fc_s + e_ctl_a[1];
            if (busy_left > 0) busy_left--;
            else if (x_mul_start && !x_branch_taken) busy_left = MUL_LAT - 1;
         end
         advance();
      end
      rst = 1'b0;
      set_idle();
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      #1;
      test_reset();
      test_load_use();
      test_forward();
      test_mul();
      test_branch();
      test_reset_busy();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall/flush controller for the MIPS pipeline (IF/ID/EX/MEM, register writeback from MEM stage).
- Generalises the fixed, hazard-free stage chaining of the current CPU top.
- Adds RAW forwarding selects, load-use interlock, taken-branch flush, and a multi-cycle EX (multiply) busy sequencer.
- Adds saturating stall and flush performance counters.

Parameters:
- RA_W, 5, register-address width.
- MUL_LAT, 4, total EX cycles occupied by a multi-cycle op (≥2).
- FWD_EN, 1: 1 = forward from MEM/WB; 0 = interlock on every RAW hazard instead.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- d_rs, d_rt  in  RA_W  source registers of instruction in ID
- d_use_rs, d_use_rt  in  1  source actually read
- x_rd  in  RA_W  dest reg in EX
- x_wen  in  1  EX instr writes reg
- x_lw  in  1  EX instr is a load
- x_mul_start  in  1  EX instr is multi-cycle (pulse on entry)
- x_branch_taken  in  1  branch resolved taken in EX
- m_rd  in  RA_W  dest reg in MEM
- m_wen  in  1  MEM instr writes reg
- w_rd  in  RA_W  dest reg at writeback
- w_wen  in  1  writeback enable
- pc_stall  out  1  hold PC
- fd_stall  out  1  hold IF/ID register
- dx_bubble  out  1  load NOP into ID/EX
- dx_hold  out  1  hold ID/EX and EX state
- xm_bubble  out  1  load NOP into EX/MEM
- fd_flush  out  1  clear IF/ID register
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- ex_busy  out  1  multi-cycle op in progress
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flushes

Behaviour:
- Register 0 never creates a hazard and never forwards; any match against 0 is ignored.
- Register file is write-through, so writeback-stage matches never stall.
- Forwarding (FWD_EN=1), combinational, independently for a and b:
  - src==m_rd && m_wen → 01.
  - else src==w_rd && w_wen → 10.
  - else 00.
  - MEM has priority over WB.
  - Outputs 00 when the corresponding use bit is 0.
  - With FWD_EN=0, fwd_a and fwd_b are constant 00.
- Load-use: x_lw && x_wen && x_rd matches a used source → pc_stall=fd_stall=dx_bubble=1 for exactly that cycle.
- FWD_EN=0 additionally stalls the same way on any used-source match with (x_rd, x_wen) or (m_rd, m_wen).
- Branch flush: x_branch_taken → fd_flush=1, dx_bubble=1, pc_stall=0 in the same cycle. Flush overrides load-use/RAW stall.
- Multi-cycle FSM, states IDLE and BUSY, down-counter cnt:
  - IDLE, x_mul_start=1, x_branch_taken=0 → BUSY with cnt=MUL_LAT-2.
  - In BUSY: ex_busy=pc_stall=fd_stall=dx_hold=xm_bubble=1, dx_bubble=0.
  - cnt decrements each cycle; cnt==0 in BUSY → IDLE next cycle.
  - Total EX occupancy is MUL_LAT cycles: the start cycle plus MUL_LAT-1 BUSY cycles.
  - x_mul_start with x_branch_taken is illegal; the branch wins and mul_start is ignored.
  - x_mul_start in BUSY is ignored.
  - The start cycle itself is not a stall cycle.
- Priority per cycle: rst > BUSY > flush > load-use/RAW stall > none.
- Counters:
  - stall_cnt += 1 each cycle pc_stall=1.
  - flush_cnt += 1 each cycle fd_flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset:
  - State IDLE, cnt=0, counters 0.
  - While rst=1: pc_stall=fd_stall=dx_hold=xm_bubble=ex_busy=0, dx_bubble=1, fd_flush=1, fwd=00. Counters do not count the reset flush.
  - Reset mid-BUSY aborts immediately; the next cycle after rst deasserts is IDLE.

Test Plan:
- x_lw=1, x_wen=1, x_rd=8, d_rs=8, d_use_rs=1 → pc_stall=fd_stall=dx_bubble=1 for 1 cycle, stall_cnt=1. Same with x_rd=0 → no stall.
- m_rd=w_rd=9, both wen, d_rt=9, d_use_rt=1 → fwd_b=01. Drop m_wen → fwd_b=10. Drop d_use_rt → 00. FWD_EN=0 with m_rd=9 → stall=1, fwd_b=00.
- x_mul_start pulse, MUL_LAT=4 → ex_busy=1 for exactly 3 cycles following start. pc_stall and xm_bubble track ex_busy; stall_cnt=3.
- x_branch_taken coincident with load-use match → fd_flush=1, dx_bubble=1, pc_stall=0, flush_cnt=1, stall_cnt unchanged.
- rst asserted during the 2nd BUSY cycle → outputs at reset values. After release ex_busy=0; a new x_mul_start gives the full 3 busy cycles.
- CNT_W=4, hold a load-use condition for 20 cycles → stall_cnt stops at 15.
